fetch_stall_ctrl: RTL

//  Sequencing controller for the fetch stage: arbitrates redirect, GPU, dependency and branch stall requests.

---
 rtl/fetch_stall_ctrl_pkg.sv | 51 +++++
 rtl/fetch_stall_ctrl_if.sv | 39 +++
 rtl/fetch_stall_ctrl_sat_counter.sv | 36 +++
 rtl/fetch_stall_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared types for the fetch stall controller: FSM states, PC-select codes
// and the priority decode that turns stall requests into fetch controls.
package fetch_stall_ctrl_pkg;

  localparam int unsigned PcWidthDefault = 16;
  localparam int unsigned PcIncr         = 4;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRun  = 3'd1,
    StDep  = 3'd2,
    StBrw  = 3'd3,
    StGpu  = 3'd4
  } fsm_state_e;

  typedef enum logic [1:0] {
    PcSelHold = 2'b00,
    PcSelInc  = 2'b01,
    PcSelBr   = 2'b10,
    PcSelRst  = 2'b11
  } pc_sel_e;

  typedef struct packed {
    pc_sel_e    pc_sel;
    logic       latch_keep;
    logic       fe_valid;
    fsm_state_e next_state;
  } ctrl_t;

  // One priority chain drives both the controls and the next state, so they never disagree.
  function automatic ctrl_t decode_ctrl(input logic rst, input logic lock, input logic redir,
                                        input logic gpu, input logic dep, input logic br_stall);
    ctrl_t c;
    c = '{pc_sel: PcSelInc, latch_keep: 1'b0, fe_valid: 1'b1, next_state: StRun};
    if (rst || !lock) begin
      c = '{pc_sel: PcSelRst, latch_keep: 1'b0, fe_valid: 1'b0, next_state: StIdle};
    end else if (redir) begin
      c = '{pc_sel: PcSelBr, latch_keep: 1'b0, fe_valid: 1'b1, next_state: StRun};
    end else if (gpu) begin
      c = '{pc_sel: PcSelHold, latch_keep: 1'b1, fe_valid: 1'b1, next_state: StGpu};
    end else if (dep) begin
      // Dep outranks an in-flight branch: the held instruction stays valid.
      c = '{pc_sel: PcSelHold, latch_keep: 1'b1, fe_valid: 1'b1, next_state: StDep};
    end else if (br_stall) begin
      // Keep advancing the PC but issue a bubble until the target resolves.
      c = '{pc_sel: PcSelInc, latch_keep: 1'b0, fe_valid: 1'b0, next_state: StBrw};
    end
    return c;
  endfunction

endpackage

// File: rtl/fetch_stall_ctrl_if.sv
// Stall-request inputs and fetch-control outputs of the fetch stall controller.
// master: stall sources / Fetch side; slave: the controller.
interface fetch_stall_ctrl_if
  import fetch_stall_ctrl_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = PcWidthDefault,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 I_LOCK;
  logic                 I_BranchAddrSelect;
  logic [PC_WIDTH-1:0]  I_BranchPC;
  logic                 I_BranchStallSignal;
  logic                 I_DepStallSignal;
  logic                 I_GPUStallSignal;
  logic [PC_WIDTH-1:0]  I_CurPC;
  logic [1:0]           O_PCSel;
  logic [PC_WIDTH-1:0]  O_NextPC;
  logic                 O_LatchKeep;
  logic                 O_FE_Valid;
  logic [2:0]           O_State;
  logic                 O_BrTimeout;
  logic [CNT_WIDTH-1:0] O_DepStallCnt;
  logic [CNT_WIDTH-1:0] O_GPUStallCnt;
  logic [CNT_WIDTH-1:0] O_BrStallCnt;

  modport master (
    output I_LOCK, I_BranchAddrSelect, I_BranchPC, I_BranchStallSignal,
    output I_DepStallSignal, I_GPUStallSignal, I_CurPC,
    input  O_PCSel, O_NextPC, O_LatchKeep, O_FE_Valid, O_State, O_BrTimeout,
    input  O_DepStallCnt, O_GPUStallCnt, O_BrStallCnt
  );

  modport slave (
    input  I_LOCK, I_BranchAddrSelect, I_BranchPC, I_BranchStallSignal,
    input  I_DepStallSignal, I_GPUStallSignal, I_CurPC,
    output O_PCSel, O_NextPC, O_LatchKeep, O_FE_Valid, O_State, O_BrTimeout,
    output O_DepStallCnt, O_GPUStallCnt, O_BrStallCnt
  );
endinterface

// File: rtl/fetch_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and synchronous active-high reset.
module fetch_stall_ctrl_sat_counter #(
  parameter int unsigned     WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}}
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Clear wins over increment; the count sticks once it reaches MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Fetch-stage sequencing controller: arbitrates redirect, GPU, dependency and
// branch stall requests into PC-select / latch-hold / fetch-valid controls,
// tracks the stall cause in a registered FSM and flags long branch waits.
// Optional feature: define FETCH_STALL_STATS_EN to build the stall statistics
// counters; otherwise the statistics outputs are tied to zero.
module fetch_stall_ctrl
  import fetch_stall_ctrl_pkg::*;
#(
  parameter int unsigned         PC_WIDTH    = PcWidthDefault,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned         BR_WAIT_MAX = 8,
  parameter int unsigned         CNT_WIDTH   = 16
) (
  input logic               I_CLOCK,
  input logic               I_RESET,
  fetch_stall_ctrl_if.slave bus
);

  localparam int unsigned             BrCntWidth = $clog2(BR_WAIT_MAX + 1);
  localparam logic [BrCntWidth-1:0]   BrCntMax   = BrCntWidth'(BR_WAIT_MAX);

  ctrl_t                 ctrl;
  fsm_state_e            state_q, state_d;
  logic                  br_wait_inc;
  logic                  br_wait_clr;
  logic [BrCntWidth-1:0] br_wait_cnt;
  logic                  timeout_q, timeout_d;

  // Priority decode of the stall requests; also yields the FSM next state.
  always_comb begin
    ctrl    = decode_ctrl(I_RESET, bus.I_LOCK, bus.I_BranchAddrSelect, bus.I_GPUStallSignal,
                          bus.I_DepStallSignal, bus.I_BranchStallSignal);
    state_d = ctrl.next_state;
  end

  // Stall-cause state register.
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-PC mux driven by the decoded PC select.
  always_comb begin
    bus.O_NextPC = bus.I_CurPC;
    unique case (ctrl.pc_sel)
      PcSelHold: bus.O_NextPC = bus.I_CurPC;
      PcSelInc:  bus.O_NextPC = bus.I_CurPC + PC_WIDTH'(PcIncr);
      PcSelBr:   bus.O_NextPC = bus.I_BranchPC;
      PcSelRst:  bus.O_NextPC = RESET_PC;
    endcase
  end

  assign bus.O_PCSel     = ctrl.pc_sel;
  assign bus.O_LatchKeep = ctrl.latch_keep;
  assign bus.O_FE_Valid  = ctrl.fe_valid;
  assign bus.O_State     = state_q;

  // Only back-to-back branch-wait cycles count; any other next state restarts the wait.
  assign br_wait_inc = (state_d == StBrw) && (state_q == StBrw);
  assign br_wait_clr = (state_d != StBrw);

  fetch_stall_ctrl_sat_counter #(
    .WIDTH (BrCntWidth),
    .MAX   (BrCntMax)
  ) u_br_wait_cnt (
    .clk_i (I_CLOCK),
    .rst_i (I_RESET),
    .inc_i (br_wait_inc),
    .clr_i (br_wait_clr),
    .cnt_o (br_wait_cnt)
  );

  // Timeout rises on the edge where the wait count reaches its limit, then sticks
  // until reset or the pipeline is disabled.
  always_comb begin
    timeout_d = timeout_q;
    if (!bus.I_LOCK) begin
      timeout_d = 1'b0;
    end else if (br_wait_inc && (br_wait_cnt >= BrCntMax - BrCntWidth'(1))) begin
      timeout_d = 1'b1;
    end
  end

  // Sticky timeout flag.
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign bus.O_BrTimeout = timeout_q;

`ifdef FETCH_STALL_STATS_EN
  // The next state already encodes the winning cause under lock and without reset.
  fetch_stall_ctrl_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_dep_stat (
    .clk_i (I_CLOCK),
    .rst_i (I_RESET),
    .inc_i (state_d == StDep),
    .clr_i (1'b0),
    .cnt_o (bus.O_DepStallCnt)
  );

  fetch_stall_ctrl_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_gpu_stat (
    .clk_i (I_CLOCK),
    .rst_i (I_RESET),
    .inc_i (state_d == StGpu),
    .clr_i (1'b0),
    .cnt_o (bus.O_GPUStallCnt)
  );

  fetch_stall_ctrl_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_br_stat (
    .clk_i (I_CLOCK),
    .rst_i (I_RESET),
    .inc_i (state_d == StBrw),
    .clr_i (1'b0),
    .cnt_o (bus.O_BrStallCnt)
  );
`else
  assign bus.O_DepStallCnt = '0;
  assign bus.O_GPUStallCnt = '0;
  assign bus.O_BrStallCnt  = '0;
`endif

endmodule
